hd44780_responder: RTL
======================

# hd44780_responder

Synthesizable HD44780-compatible LCD controller model: the receiving end of the 4-bit E/RS/DB write interface driven by the LCD driver block. Samples the bus, assembles nibbles, executes the instruction set against an internal 80-byte DDRAM, and exposes busy, register state, sticky protocol-error flags and a DDRAM read port. Used as an on-chip loopback target and as the checker in driver benches.

## Interface
- CMD_CYCLES, 16: busy duration, in clk cycles, after any instruction or data write except clear/home.
- CLEAR_CYCLES, 400: busy duration after clear display or return home; must be ≥ 80.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- e  in  1  LCD enable; asynchronous to clk; write strobe on falling edge.
- rs  in  1  0 = instruction, 1 = data.
- db  in  4  data bus (DB7..DB4).
- rd_addr  in  7  DDRAM address to read (HD44780 address space).
- rd_data  out  8  DDRAM byte at rd_addr, registered, 1-cycle latency; 0x00 for unmapped addresses.
- busy  out  1  busy flag.
- ac  out  7  address counter.
- four_bit  out  1  interface is in 4-bit mode.
- disp_on, cursor_on, blink  out  1 each  display-control bits D, C, B.
- id, sh  out  1 each  entry-mode bits.
- lines2, font  out  1 each  function-set bits N, F.
- err_busy  out  1  sticky: strobe received while busy.
- err_rs  out  1  sticky: RS differed between high and low nibble of one transfer.

## Operation
- e, rs, db pass through a 2-flop synchronizer; a falling edge of synchronized e is a strobe; rs/db are captured from the same synchronizer stage.
- 8-bit mode (after reset): each strobe is a full byte {db, 4'b0000}.
- 4-bit mode: first strobe supplies [7:4], second [3:0]; a nibble-phase bit tracks this. Only the second strobe executes.
- Strobe while busy: discarded, nibble phase unchanged, err_busy set.
- Instruction decode (highest set bit wins):
  - 0x01 clear: write 0x20 to all 80 DDRAM cells, ac=0, id=1; busy for CLEAR_CYCLES.
  - 0x02/0x03 home: ac=0; busy for CLEAR_CYCLES.
  - 0x04 entry mode: id=b1, sh=b0.
  - 0x08 display control: disp_on=b2, cursor_on=b1, blink=b0.
  - 0x10 shift: S/C=0 moves ac by ±1 (R/L=1 is +1) with wrap rules; S/C=1 has no effect on state.
  - 0x20 function set: four_bit=~b4; lines2, font updated only when in 4-bit mode. Entering 4-bit mode resets nibble phase to high.
  - 0x40 set CGRAM address: sets cgram mode; subsequent data writes discarded but still step ac.
  - 0x80 set DDRAM address: ac=b[6:0], clears cgram mode.
- Data write (RS=1): in DDRAM mode write byte at ac (unmapped ac: write dropped), then step ac by id.
- ac stepping, lines2=1: 0x27+1→0x40, 0x67+1→0x00, 0x00−1→0x67, 0x40−1→0x27. lines2=0: range 0x00..0x4F, wraps both directions.
- DDRAM index: lines2=1 maps 0x00-0x27→0-39, 0x40-0x67→40-79; lines2=0 maps 0x00-0x4F→0-79.
- FSM states: INIT_CLR, IDLE, CLR_SWEEP, WAIT. INIT_CLR/CLR_SWEEP write one cell per cycle for 80 cycles, then go to WAIT (clear) or IDLE (init). WAIT counts down its busy count, then IDLE.

## Timing
- Reset values: busy=1, ac=0, four_bit=0, id=1, sh=0, disp_on=cursor_on=blink=0, lines2=font=0, err_busy=err_rs=0, rd_data=0, nibble phase high, state INIT_CLR.
- After reset release: 80-cycle sweep, then busy=0.
- Strobe latency: e falling at input → strobe detected 3 clk later; the instruction executes, and busy rises, in that cycle.
- busy stays high for exactly CMD_CYCLES/CLEAR_CYCLES cycles, counted from the execute cycle.
- Reset mid-sweep or mid-busy: abort and restart INIT_CLR.

## Structure
- Package hd44780_pkg: instruction opcode masks, line start/end addresses (0x00, 0x27, 0x40, 0x67, 0x4F), DDRAM depth 80, blank char 0x20.
- Sub-module hd44780_ddram: 80x8, one synchronous write port, one registered read port, no reset on contents.

## Test plan
- Reset, wait 81 cycles → busy=0; rd_addr 0x00, 0x67 → 0x20.
- Single nibble 0x2, then 0x2/0x8 pair → four_bit=1, lines2=1.
- Nibbles 0x8/0x0, then data 0x4/0x1 → DDRAM 0x00=0x41, ac=0x01; busy high 16 cycles.
- Set ac 0x27, write 0x42 → DDRAM 0x27=0x42, ac=0x40; with id=0 from ac 0x00 → ac=0x67.
- Strobe 5 cycles after a data write → err_busy=1, nibble dropped; the next clean pair executes normally.
- Clear 0x0/0x1 after writes → all cells 0x20, ac=0, busy high 400 cycles; assert rst mid-sweep → busy=1, full re-init sweep.

Source files
------------

// File: rtl/hd44780_pkg.sv
// Shared constants, instruction decode and DDRAM address helpers for the
// HD44780 responder model.
package hd44780_pkg;

    localparam int         DDRAM_DEPTH  = 80;
    localparam logic [7:0] BLANK_CHAR   = 8'h20;
    localparam logic [6:0] LINE_LEN     = 7'd40;

    localparam logic [6:0] LINE1_START  = 7'h00;
    localparam logic [6:0] LINE1_END    = 7'h27;
    localparam logic [6:0] LINE2_START  = 7'h40;
    localparam logic [6:0] LINE2_END    = 7'h67;
    localparam logic [6:0] ONE_LINE_END = 7'h4F;

    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPLAY = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNC    = 8'h20;
    localparam logic [7:0] OP_CGRAM   = 8'h40;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    typedef enum logic [3:0] {
        INS_NOP,
        INS_CLEAR,
        INS_HOME,
        INS_ENTRY,
        INS_DISPLAY,
        INS_SHIFT,
        INS_FUNC,
        INS_CGRAM,
        INS_DDRAM
    } instr_e;

    typedef struct packed {
        logic       valid;
        logic [6:0] idx;
    } ddram_map_t;

    // The highest set opcode bit selects the instruction.
    function automatic instr_e decodeInstr(input logic [7:0] b);
        instr_e ins;
        if      (|(b & OP_DDRAM))   ins = INS_DDRAM;
        else if (|(b & OP_CGRAM))   ins = INS_CGRAM;
        else if (|(b & OP_FUNC))    ins = INS_FUNC;
        else if (|(b & OP_SHIFT))   ins = INS_SHIFT;
        else if (|(b & OP_DISPLAY)) ins = INS_DISPLAY;
        else if (|(b & OP_ENTRY))   ins = INS_ENTRY;
        else if (|(b & OP_HOME))    ins = INS_HOME;
        else if (|(b & OP_CLEAR))   ins = INS_CLEAR;
        else                        ins = INS_NOP;
        return ins;
    endfunction

    function automatic logic [6:0] stepAddr(input logic [6:0] a, input logic up,
                                            input logic twoLine);
        logic [6:0] n;
        if (twoLine) begin
            if (up) begin
                if      (a == LINE1_END) n = LINE2_START;
                else if (a == LINE2_END) n = LINE1_START;
                else                     n = a + 7'd1;
            end else begin
                if      (a == LINE1_START) n = LINE2_END;
                else if (a == LINE2_START) n = LINE1_END;
                else                       n = a - 7'd1;
            end
        end else begin
            if (up) n = (a >= ONE_LINE_END) ? LINE1_START : a + 7'd1;
            else    n = (a == LINE1_START) ? ONE_LINE_END : a - 7'd1;
        end
        return n;
    endfunction

    function automatic ddram_map_t mapAddr(input logic [6:0] a, input logic twoLine);
        ddram_map_t m;
        m.valid = 1'b0;
        m.idx   = '0;
        if (twoLine) begin
            if (a <= LINE1_END) begin
                m.valid = 1'b1;
                m.idx   = a;
            end else if (a >= LINE2_START && a <= LINE2_END) begin
                m.valid = 1'b1;
                m.idx   = a - LINE2_START + LINE_LEN;
            end
        end else if (a <= ONE_LINE_END) begin
            m.valid = 1'b1;
            m.idx   = a;
        end
        return m;
    endfunction

endpackage

// File: rtl/hd44780_ddram.sv
// 80x8 display data RAM: one synchronous write port and one registered read
// port that returns zero when the requested address is unmapped.
module hd44780_ddram
    import hd44780_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_we,
    input  logic [6:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic       i_rvalid,
    input  logic [6:0] i_raddr,
    output logic [7:0] o_rdata
);

    logic [7:0] r_mem [DDRAM_DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Only the output register is reset; the array contents are initialised
    // by the controller's power-on sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 8'h00;
        end else begin
            r_rdata <= i_rvalid ? r_mem[i_raddr] : 8'h00;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/hd44780_responder.sv
// HD44780-compatible receiver: synchronises the E/RS/DB write bus, assembles
// nibbles, executes instructions and data writes against the DDRAM.
module hd44780_responder
    import hd44780_pkg::*;
#(
    parameter int CMD_CYCLES   = 16,
    parameter int CLEAR_CYCLES = 400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic       rs,
    input  logic [3:0] db,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic [6:0] ac,
    output logic       four_bit,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink,
    output logic       id,
    output logic       sh,
    output logic       lines2,
    output logic       font,
    output logic       err_busy,
    output logic       err_rs
);

    localparam logic [1:0] ST_INIT_CLR  = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_CLR_SWEEP = 2'd2;
    localparam logic [1:0] ST_WAIT      = 2'd3;

    localparam int MAX_CYCLES = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    // The sweep already accounts for 80 busy cycles; WAIT covers the remainder.
    localparam int CLR_TAIL_I = (CLEAR_CYCLES > 81) ? (CLEAR_CYCLES - 81) : 0;

    localparam logic [CW-1:0] CMD_LOAD   = CW'(CMD_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0] CLR_TAIL   = CW'(CLR_TAIL_I);
    localparam logic [6:0]    LAST_IDX   = 7'(DDRAM_DEPTH - 1);

    logic          r_eSync1, r_eSync2, r_ePrev;
    logic          r_rsSync1, r_rsSync2;
    logic [3:0]    r_dbSync1, r_dbSync2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic [6:0]    r_sweepIdx;
    logic [6:0]    r_ac;
    logic          r_fourBit, r_dispOn, r_cursorOn, r_blink;
    logic          r_id, r_sh, r_lines2, r_font;
    logic          r_errBusy, r_errRs, r_cgram;
    logic          r_nibLow;
    logic [3:0]    r_hiNib;
    logic          r_hiRs;

    logic          w_strobe, w_idle, w_accept, w_exec, w_sweeping;
    logic [7:0]    w_byte;
    instr_e        w_instr;
    ddram_map_t    w_acMap, w_rdMap;
    logic          w_we;
    logic [6:0]    w_waddr;
    logic [7:0]    w_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_eSync1  <= 1'b0;
            r_eSync2  <= 1'b0;
            r_ePrev   <= 1'b0;
            r_rsSync1 <= 1'b0;
            r_rsSync2 <= 1'b0;
            r_dbSync1 <= 4'h0;
            r_dbSync2 <= 4'h0;
        end else begin
            r_eSync1  <= e;
            r_eSync2  <= r_eSync1;
            r_ePrev   <= r_eSync2;
            r_rsSync1 <= rs;
            r_rsSync2 <= r_rsSync1;
            r_dbSync1 <= db;
            r_dbSync2 <= r_dbSync1;
        end
    end

    assign w_strobe   = r_ePrev & ~r_eSync2;
    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = w_strobe & w_idle;
    assign w_exec     = w_accept & (~r_fourBit | r_nibLow);
    assign w_byte     = r_fourBit ? {r_hiNib, r_dbSync2} : {r_dbSync2, 4'b0000};
    assign w_instr    = decodeInstr(w_byte);
    assign w_sweeping = (r_state == ST_INIT_CLR) || (r_state == ST_CLR_SWEEP);
    assign w_acMap    = mapAddr(r_ac, r_lines2);
    assign w_rdMap    = mapAddr(rd_addr, r_lines2);

    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_acMap.idx;
        w_wdata = w_byte;
        if (w_sweeping) begin
            w_we    = 1'b1;
            w_waddr = r_sweepIdx;
            w_wdata = BLANK_CHAR;
        end else if (w_exec && r_rsSync2 && !r_cgram && w_acMap.valid) begin
            w_we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_INIT_CLR;
            r_count    <= '0;
            r_sweepIdx <= '0;
            r_ac       <= '0;
            r_fourBit  <= 1'b0;
            r_dispOn   <= 1'b0;
            r_cursorOn <= 1'b0;
            r_blink    <= 1'b0;
            r_id       <= 1'b1;
            r_sh       <= 1'b0;
            r_lines2   <= 1'b0;
            r_font     <= 1'b0;
            r_errBusy  <= 1'b0;
            r_errRs    <= 1'b0;
            r_cgram    <= 1'b0;
            r_nibLow   <= 1'b0;
            r_hiNib    <= 4'h0;
            r_hiRs     <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT_CLR, ST_CLR_SWEEP: begin
                    if (r_sweepIdx == LAST_IDX) begin
                        r_sweepIdx <= '0;
                        if (r_state == ST_CLR_SWEEP && CLEAR_CYCLES > 80) begin
                            r_state <= ST_WAIT;
                            r_count <= CLR_TAIL;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_sweepIdx <= r_sweepIdx + 7'd1;
                    end
                end
                ST_WAIT: begin
                    if (r_count == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                default: begin
                    if (w_exec) begin
                        r_state <= ST_WAIT;
                        r_count <= CMD_LOAD;
                        if (r_rsSync2) begin
                            r_ac <= stepAddr(r_ac, r_id, r_lines2);
                        end else begin
                            case (w_instr)
                                INS_CLEAR: begin
                                    r_state    <= ST_CLR_SWEEP;
                                    r_sweepIdx <= '0;
                                    r_ac       <= '0;
                                    r_id       <= 1'b1;
                                    r_cgram    <= 1'b0;
                                end
                                INS_HOME: begin
                                    r_count <= CLEAR_LOAD;
                                    r_ac    <= '0;
                                    r_cgram <= 1'b0;
                                end
                                INS_ENTRY: begin
                                    r_id <= w_byte[1];
                                    r_sh <= w_byte[0];
                                end
                                INS_DISPLAY: begin
                                    r_dispOn   <= w_byte[2];
                                    r_cursorOn <= w_byte[1];
                                    r_blink    <= w_byte[0];
                                end
                                INS_SHIFT: begin
                                    if (!w_byte[3]) begin
                                        r_ac <= stepAddr(r_ac, w_byte[2], r_lines2);
                                    end
                                end
                                INS_FUNC: begin
                                    r_fourBit <= ~w_byte[4];
                                    if (r_fourBit) begin
                                        r_lines2 <= w_byte[3];
                                        r_font   <= w_byte[2];
                                    end
                                end
                                INS_CGRAM: r_cgram <= 1'b1;
                                INS_DDRAM: begin
                                    r_ac    <= w_byte[6:0];
                                    r_cgram <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase

            if (w_strobe && !w_idle) begin
                r_errBusy <= 1'b1;
            end

            // Nibble phase only advances on accepted strobes; every executed
            // transfer (including entering 4-bit mode) returns it to high.
            if (w_accept) begin
                if (r_fourBit && !r_nibLow) begin
                    r_hiNib  <= r_dbSync2;
                    r_hiRs   <= r_rsSync2;
                    r_nibLow <= 1'b1;
                end else begin
                    r_nibLow <= 1'b0;
                    if (r_fourBit && (r_hiRs != r_rsSync2)) begin
                        r_errRs <= 1'b1;
                    end
                end
            end
        end
    end

    hd44780_ddram u_ddram (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_rvalid (w_rdMap.valid),
        .i_raddr  (w_rdMap.idx),
        .o_rdata  (rd_data)
    );

    assign busy      = ~w_idle;
    assign ac        = r_ac;
    assign four_bit  = r_fourBit;
    assign disp_on   = r_dispOn;
    assign cursor_on = r_cursorOn;
    assign blink     = r_blink;
    assign id        = r_id;
    assign sh        = r_sh;
    assign lines2    = r_lines2;
    assign font      = r_font;
    assign err_busy  = r_errBusy;
    assign err_rs    = r_errRs;

endmodule
